// File: rtl/serial_subtractor.sv
// Bit-serial A - B - bin, LSB first, one bit per clock; done pulses WIDTH cycles after the start edge.
// No backpressure: start is accepted only in IDLE, and a start seen while busy is dropped rather than queued.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d, br_nxt, last;

  assign d      = a_sh[0] ^ b_sh[0] ^ br;
  assign br_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
  assign last   = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      res  <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= A;
            b_sh <= B;
            br   <= bin;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          res  <= {d, res[WIDTH-1:1]};
          br   <= br_nxt;
          cnt  <= cnt + CW'(1);
          // On the final bit the operand MSBs sit at bit 0 and d is the result MSB.
          if (last) begin
            diff <= {d, res[WIDTH-1:1]};
            bout <= br_nxt;
            ovf  <= (a_sh[0] ^ b_sh[0]) & (d ^ a_sh[0]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive checks of serial_subtractor at WIDTH=4.
module tb_serial_subtractor;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         bin = 1'b0;
  logic         busy, done, bout, ovf;
  logic [W-1:0] diff;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation, wait (bounded) for done, check latency and results, return to IDLE.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bi, input logic [W-1:0] ed, input logic eb, input logic eo);
    int lat;
    bit got;
    @(negedge clk);
    A = a; B = b; bin = bi; start = 1'b1;
    edge_sample();
    @(negedge clk);
    start = 1'b0; A = ~a; B = ~b; bin = ~bi;
    lat = 0;
    got = 1'b0;
    for (int i = 1; i <= 3 * W && !got; i++) begin
      edge_sample();
      if (done) begin
        got = 1'b1;
        lat = i;
      end
    end
    check({tag, "_done_seen"}, 16'(got), 16'd1);
    check({tag, "_latency"}, 16'(lat), 16'(W));
    check({tag, "_diff"}, 16'(diff), 16'(ed));
    check({tag, "_bout"}, 16'(bout), 16'(eb));
    check({tag, "_ovf"}, 16'(ovf), 16'(eo));
    edge_sample();
    check({tag, "_idle_busy"}, 16'(busy), 16'd0);
  endtask

  initial begin
    int dones;
    logic [W:0]   full;
    logic [W-1:0] ed;
    logic         eo;

    #2;
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_diff", 16'(diff), 16'd0);
    check("rst_bout_ovf", {14'd0, bout, ovf}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    edge_sample();
    check("idle_hold_busy", 16'(busy), 16'd0);

    // Cycle-accurate walk of 7 - 3 with operand changes after the sampling edge.
    @(negedge clk);
    A = 4'd7; B = 4'd3; bin = 1'b0; start = 1'b1;
    edge_sample();
    check("n0_busy", 16'(busy), 16'd1);
    check("n0_done", 16'(done), 16'd0);
    @(negedge clk);
    start = 1'b0; A = 4'hF; B = 4'hF; bin = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      edge_sample();
      check("run_busy", 16'(busy), 16'd1);
      check("run_done", 16'(done), 16'd0);
      check("run_diff_held", 16'(diff), 16'd0);
    end
    edge_sample();
    check("n4_done", 16'(done), 16'd1);
    check("n4_diff", 16'(diff), 16'd4);
    check("n4_bout", 16'(bout), 16'd0);
    check("n4_ovf", 16'(ovf), 16'd0);
    edge_sample();
    check("n5_busy", 16'(busy), 16'd0);
    check("n5_done", 16'(done), 16'd0);
    check("n5_diff_hold", 16'(diff), 16'd4);

    do_op("a3b7", 4'd3, 4'd7, 1'b0, 4'hC, 1'b1, 1'b0);
    do_op("a8b1", 4'd8, 4'd1, 1'b0, 4'd7, 1'b0, 1'b1);
    do_op("a0b0c1", 4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0);

    // Starts during RUN (before N+2) and DONE (before N+5) must be ignored.
    @(negedge clk);
    A = 4'd7; B = 4'd3; bin = 1'b0; start = 1'b1;
    edge_sample();
    dones = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 2 || i == 5) begin
        start = 1'b1; A = 4'hF; B = 4'hF;
      end else begin
        start = 1'b0;
      end
      edge_sample();
      if (done) dones++;
      if (i == 5) check("ign_n5_busy", 16'(busy), 16'd0);
    end
    check("ign_done_count", 16'(dones), 16'd1);
    check("ign_diff", 16'(diff), 16'd4);
    check("ign_busy_end", 16'(busy), 16'd0);

    // Asynchronous reset mid-RUN aborts the operation.
    @(negedge clk);
    A = 4'd7; B = 4'd3; bin = 1'b0; start = 1'b1;
    edge_sample();
    @(negedge clk);
    start = 1'b0;
    edge_sample();
    edge_sample();
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 16'(busy), 16'd0);
    check("arst_diff", 16'(diff), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      edge_sample();
      if (done) dones++;
    end
    check("arst_no_done", 16'(dones), 16'd0);
    do_op("a5b2", 4'd5, 4'd2, 1'b0, 4'd3, 1'b0, 1'b0);

    // Exhaustive sweep against an arithmetic reference.
    for (int ci = 0; ci < 2; ci++) begin
      for (int ai = 0; ai < 16; ai++) begin
        for (int bi = 0; bi < 16; bi++) begin
          full = {1'b0, 4'(ai)} - {1'b0, 4'(bi)} - 5'(ci);
          ed   = full[W-1:0];
          eo   = (ai[W-1] != bi[W-1]) && (ed[W-1] != ai[W-1]);
          do_op("sweep", 4'(ai), 4'(bi), ci[0], ed, full[W], eo);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end
endmodule
